// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg: state encoding and protocol constants shared by the UDP receiver
package udp_rx_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, RX_END} state_t;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD           = 8'hD5;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [15:0] ETH_HEAD_LEN  = 16'd14;
    localparam logic [15:0] IP_HEAD_LEN   = 16'd20;
    localparam logic [15:0] UDP_HEAD_LEN  = 16'd8;
    localparam logic [47:0] BROADCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
endpackage

// File: rtl/udp_rx.sv
// udp_rx: byte-wise Ethernet/IPv4/UDP frame parser forwarding the UDP payload
module udp_rx
    import udp_rx_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rec_en,
    output logic [7:0]  rec_data,
    output logic        rec_done,
    output logic [15:0] rec_byte_num,
    output logic        rec_err
);
    state_t      state, state_nxt;
    logic [15:0] cnt, udp_len;
    logic [47:0] mac_sh;
    logic [31:0] ip_sh;
    logic        gap, uni_ok, bc_ok, uni_now, bc_now, eth_bad, ip_bad, udp_last, last;
    logic        en_nxt, done_nxt, err_nxt;

    assign mac_sh   = BOARD_MAC << {cnt[2:0], 3'b000};
    assign ip_sh    = BOARD_IP << {cnt[1:0], 3'b000};
    assign uni_now  = (cnt == 16'd0 || uni_ok) && rx_data == mac_sh[47:40];
    assign bc_now   = (cnt == 16'd0 || bc_ok) && rx_data == BROADCAST_MAC[7:0];
    assign eth_bad  = (cnt < 16'd6 && !(uni_now || bc_now))
                   || (cnt == 16'd12 && rx_data != ETH_TYPE_IPV4[15:8])
                   || (cnt == 16'd13 && rx_data != ETH_TYPE_IPV4[7:0]);
    assign ip_bad   = (cnt == 16'd0 && rx_data != IP_VER_IHL)
                   || (cnt == 16'd9 && rx_data != IP_PROTO_UDP)
                   || (cnt >= 16'd16 && rx_data != ip_sh[31:24]);
    assign udp_last = cnt == UDP_HEAD_LEN - 16'd1;
    assign last     = cnt == rec_byte_num - 16'd1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + 16'(rx_valid);
        end

    // a frame only starts on 0x55 following an idle cycle, so a frame cut by reset is never resynced mid-stream
    always_comb begin
        state_nxt = state;
        if (!rx_valid)
            state_nxt = IDLE;
        else
            case (state)
                IDLE:     state_nxt = (gap && rx_data == PREAMBLE_BYTE) ? PREAMBLE : RX_END;
                PREAMBLE: state_nxt = (cnt < 16'd6 && rx_data == PREAMBLE_BYTE) ? PREAMBLE :
                                      (cnt == 16'd6 && rx_data == SFD) ? ETH_HEAD : RX_END;
                ETH_HEAD: state_nxt = eth_bad ? RX_END : (cnt == ETH_HEAD_LEN - 16'd1) ? IP_HEAD : ETH_HEAD;
                IP_HEAD:  state_nxt = ip_bad ? RX_END : (cnt == IP_HEAD_LEN - 16'd1) ? UDP_HEAD : IP_HEAD;
                UDP_HEAD: state_nxt = !udp_last ? UDP_HEAD : (udp_len <= UDP_HEAD_LEN) ? RX_END : RX_DATA;
                RX_DATA:  state_nxt = last ? RX_END : RX_DATA;
                default:  state_nxt = RX_END;
            endcase
    end

    always_comb begin
        en_nxt   = rx_valid && state == RX_DATA;
        done_nxt = rx_valid && ((state == RX_DATA && last)
                             || (state == UDP_HEAD && udp_last && udp_len == UDP_HEAD_LEN));
        err_nxt  = (!rx_valid && state != IDLE && state != RX_END)
                || (rx_valid && state == PREAMBLE && state_nxt == RX_END)
                || (rx_valid && state == UDP_HEAD && udp_last && udp_len < UDP_HEAD_LEN);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rec_en       <= 1'b0;
            rec_done     <= 1'b0;
            rec_err      <= 1'b0;
            rec_data     <= '0;
            rec_byte_num <= '0;
            udp_len      <= '0;
            gap          <= 1'b0;
            uni_ok       <= 1'b0;
            bc_ok        <= 1'b0;
        end else begin
            rec_en   <= en_nxt;
            rec_done <= done_nxt;
            rec_err  <= err_nxt;
            rec_data <= en_nxt ? rx_data : rec_data;
            gap      <= !rx_valid;
            uni_ok   <= uni_now;
            bc_ok    <= bc_now;
            if (rx_valid && state == UDP_HEAD && cnt == 16'd4)
                udp_len[15:8] <= rx_data;
            if (rx_valid && state == UDP_HEAD && cnt == 16'd5) begin
                udp_len[7:0] <= rx_data;
                rec_byte_num <= {udp_len[15:8], rx_data} - UDP_HEAD_LEN;
            end
        end
endmodule

// File: tb/tb_udp_rx.sv
// tb_udp_rx: randomized frames checked against an index-based frame model
module tb_udp_rx;
    typedef logic [7:0] bq_t[$];
    localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] IP  = {8'd192, 8'd168, 8'd1, 8'd123};

    logic        clk = 1'b0, rst_n = 1'b1, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rec_en, rec_done, rec_err;
    logic [7:0]  rec_data;
    logic [15:0] rec_byte_num;

    int cyc = 0, cmp = 0, fails = 0;
    logic [7:0] got_pl[$];
    int got_t[$];
    int got_done = 0, got_err = 0, got_done_en = 0, got_excl = 0;
    logic [7:0] exp_pl[$];
    int exp_t[$];
    int exp_done = 0, exp_err = 0, exp_done_en = 0;
    logic [15:0] exp_num = 16'h0000;
    int b_pl = 0, b_done = 0, b_err = 0, b_den = 0;

    udp_rx dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rec_en(rec_en), .rec_data(rec_data), .rec_done(rec_done),
        .rec_byte_num(rec_byte_num), .rec_err(rec_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst_n) begin
            if (rec_en) begin
                got_pl.push_back(rec_data);
                got_t.push_back(cyc);
            end
            if (rec_done) begin
                got_done++;
                if (rec_en) got_done_en++;
            end
            if (rec_err) got_err++;
            if (rec_err && (rec_en || rec_done)) got_excl++;
        end

    task automatic mark();
        b_pl = got_pl.size(); b_done = got_done; b_err = got_err; b_den = got_done_en;
        exp_pl = {}; exp_t = {}; exp_done = 0; exp_err = 0; exp_done_en = 0;
    endtask

    function automatic int pl_diff();
        int d = (got_pl.size() - b_pl) - exp_pl.size();
        d = d < 0 ? -d : d;
        foreach (exp_pl[i])
            if (b_pl + i < got_pl.size())
                if (got_pl[b_pl + i] !== exp_pl[i] || got_t[b_pl + i] != exp_t[i]) d++;
        return d;
    endfunction

    task automatic build(input logic [47:0] dmac, input logic [31:0] dip, input logic [7:0] proto,
                         input logic [15:0] etype, input logic [15:0] ulen, input int npl, output bq_t f);
        f = {};
        repeat (7) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 0; i < 6; i++) f.push_back(dmac[47 - 8 * i -: 8]);
        repeat (6) f.push_back(8'($urandom));
        f.push_back(etype[15:8]); f.push_back(etype[7:0]);
        f.push_back(8'h45);
        repeat (8) f.push_back(8'($urandom));
        f.push_back(proto);
        repeat (6) f.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) f.push_back(dip[31 - 8 * i -: 8]);
        repeat (4) f.push_back(8'($urandom));
        f.push_back(ulen[15:8]); f.push_back(ulen[7:0]);
        repeat (2) f.push_back(8'($urandom));
        repeat (npl) f.push_back(8'($urandom));
        while (f.size() < 22 + 46) f.push_back(8'($urandom));
        repeat (4) f.push_back(8'($urandom));
    endtask

    task automatic model(input bq_t f, input int t0);
        int n = f.size();
        logic [47:0] dst = '0;
        logic [31:0] dip = '0;
        logic [15:0] ul;
        if (n == 0 || f[0] != 8'h55) return;
        for (int i = 0; i < 8; i++)
            if (i >= n || f[i] != (i == 7 ? 8'hD5 : 8'h55)) begin exp_err++; return; end
        if (n < 50) begin exp_err++; return; end
        for (int i = 0; i < 6; i++) dst = {dst[39:0], f[8 + i]};
        for (int i = 0; i < 4; i++) dip = {dip[23:0], f[38 + i]};
        if (!(dst == MAC || dst == '1) || {f[20], f[21]} != 16'h0800 ||
            f[22] != 8'h45 || f[31] != 8'h11 || dip != IP) return;
        ul = {f[46], f[47]};
        exp_num = ul - 16'd8;
        if (ul < 16'd8) begin exp_err++; return; end
        for (int j = 0; j < int'(ul) - 8; j++) begin
            if (50 + j >= n) begin exp_err++; return; end
            exp_pl.push_back(f[50 + j]);
            exp_t.push_back(t0 + 51 + j);
        end
        exp_done++;
        if (ul > 16'd8) exp_done_en++;
    endtask

    task automatic send(input bq_t f, input int gap);
        model(f, cyc);
        foreach (f[i]) begin
            rx_valid = 1'b1; rx_data = f[i];
            @(negedge clk);
        end
        rx_valid = 1'b0; rx_data = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        cmp += 2;
        if ({rec_en, rec_done, rec_err} !== 3'b000) begin
            fails++; $display("FAIL reset strobes: got %b want 000", {rec_en, rec_done, rec_err});
        end
        if ({rec_data, rec_byte_num} !== 24'h0) begin
            fails++; $display("FAIL reset data: got %h/%h want 00/0000", rec_data, rec_byte_num);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_unicast();
        bq_t f;
        mark();
        build(MAC, IP, 8'h11, 16'h0800, 16'd12, 4, f);
        f[50] = 8'h11; f[51] = 8'h22; f[52] = 8'h33; f[53] = 8'h44;
        send(f, 4);
        cmp += 6;
        if (exp_pl.size() != 4) begin fails++; $display("FAIL unicast model: %0d bytes want 4", exp_pl.size()); end
        if (pl_diff() != 0) begin fails++; $display("FAIL unicast payload: %0d diffs want 0", pl_diff()); end
        if (got_done - b_done != exp_done) begin fails++; $display("FAIL unicast done: got %0d want %0d", got_done - b_done, exp_done); end
        if (got_done_en - b_den != exp_done_en) begin fails++; $display("FAIL unicast done_with_en: got %0d want %0d", got_done_en - b_den, exp_done_en); end
        if (got_err - b_err != exp_err) begin fails++; $display("FAIL unicast err: got %0d want %0d", got_err - b_err, exp_err); end
        if (rec_byte_num !== 16'd4) begin fails++; $display("FAIL unicast byte_num: got %0d want 4", rec_byte_num); end
    endtask

    task automatic test_reset_mid_frame();
        bq_t f, g, h;
        mark();
        build(MAC, IP, 8'h11, 16'h0800, 16'd12, 4, f);
        build(MAC, IP, 8'h11, 16'h0800, 16'd12, 4, g);
        build(MAC, IP, 8'h11, 16'h0800, 16'd12, 4, h);
        for (int i = 0; i < 30; i++) begin
            rx_valid = 1'b1; rx_data = f[i];
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        cmp++;
        if ({rec_en, rec_done, rec_err, rec_byte_num} !== 19'h0) begin
            fails++; $display("FAIL midreset outputs: got %b/%h want 000/0000", {rec_en, rec_done, rec_err}, rec_byte_num);
        end
        exp_num = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        foreach (g[i]) begin
            rx_data = g[i];
            @(negedge clk);
        end
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        send(h, 4);
        cmp += 4;
        if (pl_diff() != 0) begin fails++; $display("FAIL midreset payload: %0d diffs want 0", pl_diff()); end
        if (got_done - b_done != exp_done) begin fails++; $display("FAIL midreset done: got %0d want %0d", got_done - b_done, exp_done); end
        if (got_err - b_err != exp_err) begin fails++; $display("FAIL midreset err: got %0d want %0d", got_err - b_err, exp_err); end
        if (rec_byte_num !== exp_num) begin fails++; $display("FAIL midreset byte_num: got %0d want %0d", rec_byte_num, exp_num); end
    endtask

    task automatic test_broadcast_pad();
        bq_t f;
        mark();
        build(48'hFF_FF_FF_FF_FF_FF, IP, 8'h11, 16'h0800, 16'd9, 1, f);
        f[50] = 8'hA5;
        send(f, 4);
        cmp += 4;
        if (pl_diff() != 0) begin fails++; $display("FAIL bcast payload: %0d diffs want 0", pl_diff()); end
        if (got_done - b_done != exp_done) begin fails++; $display("FAIL bcast done: got %0d want %0d", got_done - b_done, exp_done); end
        if (got_err - b_err != exp_err) begin fails++; $display("FAIL bcast err: got %0d want %0d", got_err - b_err, exp_err); end
        if (rec_byte_num !== exp_num) begin fails++; $display("FAIL bcast byte_num: got %0d want %0d", rec_byte_num, exp_num); end
    endtask

    task automatic test_wrong_ip();
        bq_t f, g;
        mark();
        build(MAC, {8'd192, 8'd168, 8'd1, 8'd99}, 8'h11, 16'h0800, 16'd14, 6, f);
        build(MAC, IP, 8'h11, 16'h0800, 16'd11, 3, g);
        send(f, 2);
        send(g, 4);
        cmp += 4;
        if (pl_diff() != 0) begin fails++; $display("FAIL wrong_ip payload: %0d diffs want 0", pl_diff()); end
        if (got_done - b_done != exp_done) begin fails++; $display("FAIL wrong_ip done: got %0d want %0d", got_done - b_done, exp_done); end
        if (got_err - b_err != exp_err) begin fails++; $display("FAIL wrong_ip err: got %0d want %0d", got_err - b_err, exp_err); end
        if (rec_byte_num !== exp_num) begin fails++; $display("FAIL wrong_ip byte_num: got %0d want %0d", rec_byte_num, exp_num); end
    endtask

    task automatic test_zero_len();
        bq_t f;
        mark();
        build(MAC, IP, 8'h11, 16'h0800, 16'd8, 0, f);
        send(f, 4);
        cmp += 4;
        if (got_pl.size() != b_pl) begin fails++; $display("FAIL zero_len rec_en: got %0d want 0", got_pl.size() - b_pl); end
        if (got_done - b_done != exp_done) begin fails++; $display("FAIL zero_len done: got %0d want %0d", got_done - b_done, exp_done); end
        if (got_err - b_err != exp_err) begin fails++; $display("FAIL zero_len err: got %0d want %0d", got_err - b_err, exp_err); end
        if (rec_byte_num !== 16'd0) begin fails++; $display("FAIL zero_len byte_num: got %0d want 0", rec_byte_num); end
    endtask

    task automatic test_truncated();
        bq_t f;
        mark();
        build(MAC, IP, 8'h11, 16'h0800, 16'd18, 10, f);
        while (f.size() > 52) void'(f.pop_back());
        send(f, 4);
        cmp += 4;
        if (pl_diff() != 0) begin fails++; $display("FAIL truncated payload: %0d diffs want 0", pl_diff()); end
        if (got_done - b_done != exp_done) begin fails++; $display("FAIL truncated done: got %0d want %0d", got_done - b_done, exp_done); end
        if (got_err - b_err != exp_err) begin fails++; $display("FAIL truncated err: got %0d want %0d", got_err - b_err, exp_err); end
        if (rec_byte_num !== exp_num) begin fails++; $display("FAIL truncated byte_num: got %0d want %0d", rec_byte_num, exp_num); end
    endtask

    task automatic test_back_to_back();
        bq_t f, g;
        mark();
        build(MAC, IP, 8'h11, 16'h0800, 16'd13, 5, f);
        f[7] = 8'hD4;
        build(MAC, IP, 8'h11, 16'h0800, 16'd15, 7, g);
        send(f, 1);
        send(g, 4);
        cmp += 4;
        if (pl_diff() != 0) begin fails++; $display("FAIL back_to_back payload: %0d diffs want 0", pl_diff()); end
        if (got_done - b_done != exp_done) begin fails++; $display("FAIL back_to_back done: got %0d want %0d", got_done - b_done, exp_done); end
        if (got_err - b_err != exp_err) begin fails++; $display("FAIL back_to_back err: got %0d want %0d", got_err - b_err, exp_err); end
        if (rec_byte_num !== exp_num) begin fails++; $display("FAIL back_to_back byte_num: got %0d want %0d", rec_byte_num, exp_num); end
    endtask

    task automatic test_random();
        bq_t f;
        for (int k = 0; k < 12; k++) begin
            int kind = $urandom_range(0, 5);
            int npl  = $urandom_range(1, 30);
            mark();
            build(kind == 1 ? 48'hFF_FF_FF_FF_FF_FF : kind == 2 ? MAC ^ {40'h0, 8'($urandom_range(1, 255))} : MAC,
                  IP, kind == 4 ? 8'h06 : 8'h11, kind == 3 ? 16'h0806 : 16'h0800, 16'(npl + 8), npl, f);
            if (kind == 5) begin
                int cut = 50 + $urandom_range(0, npl - 1);
                while (f.size() > cut) void'(f.pop_back());
            end
            send(f, $urandom_range(2, 4));
            cmp += 5;
            if (pl_diff() != 0) begin fails++; $display("FAIL random[%0d] payload: %0d diffs want 0", k, pl_diff()); end
            if (got_done - b_done != exp_done) begin fails++; $display("FAIL random[%0d] done: got %0d want %0d", k, got_done - b_done, exp_done); end
            if (got_done_en - b_den != exp_done_en) begin fails++; $display("FAIL random[%0d] done_with_en: got %0d want %0d", k, got_done_en - b_den, exp_done_en); end
            if (got_err - b_err != exp_err) begin fails++; $display("FAIL random[%0d] err: got %0d want %0d", k, got_err - b_err, exp_err); end
            if (rec_byte_num !== exp_num) begin fails++; $display("FAIL random[%0d] byte_num: got %0d want %0d", k, rec_byte_num, exp_num); end
        end
        cmp++;
        if (got_excl != 0) begin fails++; $display("FAIL exclusivity: got %0d overlaps want 0", got_excl); end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_reset_mid_frame();
        test_broadcast_pad();
        test_wrong_ip();
        test_zero_len();
        test_truncated();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end
endmodule

// File: doc/udp_rx.md
UDP_RX -- requirements
Module: udp_rx

Interface
REQ-001 Parameter BOARD_MAC, default 48'h00_11_22_33_44_55, local MAC address.
REQ-002 Parameter BOARD_IP, default 192.168.1.123, local IPv4 address.
REQ-003 clk  in  1  byte clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rx_valid  in  1  high for every byte of one frame, contiguous, low in the inter-frame gap.
REQ-006 rx_data  in  8  frame byte, sampled when rx_valid is high.
REQ-007 rec_en  out  1  one-cycle strobe per accepted payload byte.
REQ-008 rec_data  out  8  payload byte, qualified by rec_en.
REQ-009 rec_done  out  1  one-cycle pulse after the last payload byte of a good frame.
REQ-010 rec_byte_num  out  16  payload length (UDP length - 8), valid from the header onward and held until the next frame.
REQ-011 rec_err  out  1  one-cycle pulse when a frame is abandoned.

Function
REQ-012 FSM states: IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, RX_END.
REQ-013 One byte counter serves all states and clears on every state transition.
REQ-014 IDLE -> PREAMBLE on rx_valid with rx_data == 8'h55.
REQ-015 PREAMBLE: 6 more 8'h55 bytes, then one 8'hD5, -> ETH_HEAD.
- Any other byte in PREAMBLE -> RX_END with rec_err.
REQ-016 ETH_HEAD: 14 bytes.
- Dest MAC (bytes 0-5) must equal BOARD_MAC or 48'hFF_FF_FF_FF_FF_FF.
- Type (bytes 12-13) must equal 16'h0800.
- On mismatch, -> RX_END without rec_err (silent drop); otherwise -> IP_HEAD.
REQ-017 IP_HEAD: 20 bytes.
- Byte 0 must be 8'h45.
- Byte 9 must be 8'h11.
- Bytes 16-19 must equal BOARD_IP.
- On mismatch, silent drop -> RX_END; otherwise -> UDP_HEAD.
- The IP header checksum is not checked.
REQ-018 UDP_HEAD: 8 bytes; capture bytes 4-5 as udp_len.
- rec_byte_num = udp_len - 8, 16-bit.
- udp_len < 8 -> RX_END with rec_err.
- udp_len == 8 -> rec_done on the cycle after byte 7, then RX_END.
- Otherwise -> RX_DATA.
- The UDP checksum is ignored.
REQ-019 RX_DATA: each input byte appears on rec_data with rec_en high exactly 1 cycle after its sampling edge (registered, latency 1).
- After rec_byte_num bytes, rec_done pulses in the same cycle as the last rec_en, then -> RX_END.
REQ-020 RX_END discards all remaining bytes: Ethernet padding, the 4 FCS bytes (not checked), and trailing bytes. It returns to IDLE on the first cycle rx_valid is low.
REQ-021 rx_valid low in any state other than IDLE or RX_END aborts the frame.
- rec_err pulses on the next cycle; the FSM goes to IDLE directly.
- rec_done is never asserted for that frame.
REQ-022 rx_valid low within a header or RX_DATA ends a frame early; no partial-length rec_done is produced.
REQ-023 rec_en, rec_done and rec_err are mutually exclusive except for the rec_en/rec_done coincidence in REQ-019.
REQ-024 A new frame is only recognised after at least one idle (rx_valid low) cycle.

Reset
REQ-025 On rst_n low, asynchronously:
- state = IDLE, counter = 0.
- rec_en = 0, rec_data = 8'h00, rec_done = 0, rec_err = 0, rec_byte_num = 16'h0000.
REQ-026 Reset mid-frame drops the frame with no rec_done or rec_err.
- After release, the remainder of the frame is ignored until rx_valid goes low.

Structure
REQ-027 A shared package holds:
- state encodings;
- PREAMBLE_BYTE 8'h55, SFD 8'hD5, ETH_TYPE_IPV4 16'h0800, IP_PROTO_UDP 8'h11;
- header lengths 14/20/8;
- the broadcast MAC constant.
REQ-028 Single module; no sub-module, as header parsing is counter-indexed within one FSM.

Verification
REQ-029 Good unicast frame, 4-byte payload 11 22 33 44 (udp_len 12) -> rec_en x4 with those bytes, rec_byte_num = 4, rec_done with the 4th byte, no rec_err.
REQ-030 Broadcast dest MAC, 1-byte payload 8'hA5 padded to 46 bytes + FCS -> one rec_en (A5), rec_done, padding not forwarded.
REQ-031 Dest IP 192.168.1.99 -> no rec_en, no rec_done, no rec_err; next good frame received normally.
REQ-032 udp_len = 8 -> rec_byte_num = 0, rec_done with no rec_en.
REQ-033 rx_valid dropped after 2 of 10 payload bytes -> 2 rec_en, rec_err pulse, no rec_done, FSM in IDLE.
REQ-034 Bad SFD 8'hD4 -> rec_err, frame ignored; back-to-back good frame accepted after 1 idle cycle.
